// File: rtl/serial_word_feeder.sv
// serial_word_feeder: double-buffered parallel-to-serial front end feeding the "111" detector
module serial_word_feeder #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int BIT_CYCLES = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sequential_output,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy,
  output logic [5:0]       words_sent
);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] shreg, hold, shifted;
  logic             hold_full, accept, slot_end, word_end, shifting;
  logic [BW-1:0]    bit_idx;
  logic [CW-1:0]    cyc;
  always_comb begin
    shifting = state == SHIFT;
    accept = load_valid & ~hold_full;
    slot_end = cyc == CYC_LAST;
    word_end = shifting & slot_end & (bit_idx == BIT_LAST);
    shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    load_ready = ~hold_full;
    sequential_output = shifting ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
    bit_valid = shifting;
    word_done = word_end;
    busy = shifting | hold_full;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      bit_idx <= '0;
      cyc <= '0;
      words_sent <= '0;
    end else if (!shifting) begin
      if (accept) begin
        state <= SHIFT;
        shreg <= load_data;
        bit_idx <= '0;
        cyc <= '0;
      end
    end else begin
      cyc <= slot_end ? '0 : cyc + 1'b1;
      if (slot_end) begin
        bit_idx <= word_end ? '0 : bit_idx + 1'b1;
        shreg <= shifted;
      end
      // at the end edge the next word (held or arriving) replaces the shifter with no gap
      if (word_end) begin
        words_sent <= words_sent + 6'd1;
        if (hold_full) begin
          shreg <= hold;
          hold_full <= 1'b0;
        end else if (accept) shreg <= load_data;
        else state <= IDLE;
      end else if (accept) begin
        hold <= load_data;
        hold_full <= 1'b1;
      end
    end
  end
endmodule
